cordic_vectoring_core: RTL and testbench
========================================

# cordic_vectoring_core

Iterative CORDIC vectoring-mode engine for the cartesian-to-polar path. It accepts one signed (x, y) sample and rotates it onto the positive x-axis. It produces the accumulated angle `theta_out` and the unscaled magnitude `r_out`, where unscaled means multiplied by the CORDIC gain. `r_out` (24-bit signed) feeds the downstream gain-compensation multiplier, which computes 24s × 22u.

## Interface
- `NUM_ITER`, 16: micro-rotations per sample; legal range 8..16.
- `ap_clk` input 1: sole clock, rising edge.
- `ap_rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `x_in`/`y_in` valid.
- `in_ready` output 1: core can accept; equals (state==IDLE).
- `x_in` input 16: signed Q1.14.
- `y_in` input 16: signed Q1.14.
- `out_valid` output 1: result valid; held until taken.
- `out_ready` input 1: downstream accepts result.
- `r_out` output 24: signed Q3.20 magnitude (gain-scaled per Configuration).
- `theta_out` output 16: signed Q2.13 radians, range [-π, π].
- `busy` output 1: state != IDLE.

## Operation
- **Internal registers:**
  - `xr`, `yr`: 24-bit signed Q3.20.
  - `zr`: 16-bit signed Q2.13.
  - `iter`: counter, 0..NUM_ITER-1.
- **Load, on an edge with in_valid & in_ready:**
  - Input is sign-extended and shifted left 6: v = sext(in) << 6.
  - If x ≥ 0: xr=vx, yr=vy, zr=0.
  - If x < 0 and y ≥ 0: xr=vy, yr=−vx, zr=+12868 (π/2).
  - If x < 0 and y < 0: xr=−vy, yr=vx, zr=−12868.
  - A zero flag is latched when x_in==0 and y_in==0.
- **Iteration i:**
  - If yr ≥ 0: xr += yr>>>i; yr −= xr>>>i; zr += ATAN[i].
  - Otherwise: xr −= yr>>>i; yr += xr>>>i; zr −= ATAN[i].
  - Both updates use old register values; shifts are arithmetic.
- **ATAN table, round(atan(2⁻ⁱ)·8192), i=0..13:** 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1. Entries for i ≥ 14 are 0.
- **States:**
  - IDLE → ROT on accept.
  - ROT: iter increments each cycle. ROT → DONE after iteration NUM_ITER−1 (→ SCALE when gain compensation is enabled).
  - SCALE → DONE after 1 cycle.
  - DONE → IDLE on out_ready.
- **Output:**
  - In DONE, r_out = xr and theta_out = zr.
  - If the zero flag is set, theta_out is forced to 0 (r_out is naturally 0).
  - Outputs are registered and stable throughout DONE.
- No overlap: a new sample is accepted only in IDLE. in_valid outside IDLE is ignored.
- Widths: no intermediate saturation. Q3.20 headroom covers |r| ≤ 2√2·1.647 < 8.

## Timing
- **Reset:**
  - State=IDLE.
  - out_valid=0, busy=0, r_out=0, theta_out=0.
  - Internal registers cleared.
  - in_ready=1 in the cycle after reset deasserts.
- **Reset mid-operation** (ROT, SCALE or DONE): the result is discarded and the core returns to IDLE on the next edge with all outputs as above.
- **Latency:**
  - Accept at edge k; out_valid is high from edge k+NUM_ITER+1 (gain compensation disabled) or k+NUM_ITER+2 (enabled).
  - Default NUM_ITER=16 gives 17 and 18 respectively.
- **Output handshake:**
  - The transfer completes on the edge where out_valid & out_ready.
  - out_valid drops on that edge; in_ready rises in the same cycle (state IDLE).
- **Back-to-back throughput:** one sample per NUM_ITER+2 cycles (NUM_ITER+3 with gain compensation).
- **Backpressure:** if out_ready is held low, out_valid, r_out and theta_out hold indefinitely and in_ready stays 0.

## Configuration
- `CORDIC_GAIN_COMP_EN`:
  - **Defined:** adds state SCALE. It computes r_out = (xr × 22'd2547004) >>> 22, where 2547004 is K≈0.60725 in Q0.22. The product is 46-bit; the result is truncated to 24-bit Q3.20. Latency is +1 cycle.
  - **Undefined:** no SCALE state; r_out is the raw gain-multiplied magnitude, for the external 24s×22u multiplier.

## Test plan
- **Reset mid-operation:**
  - Stimulus: reset at power-up, then accept (x=16384, y=0), then assert ap_rst 5 cycles after accept.
  - Response: out_valid never asserts; outputs are 0; in_ready=1 in the first cycle after ap_rst deasserts.
- **Positive x-axis:**
  - Stimulus: x=16384, y=0.
  - Response: |theta_out| ≤ 2; r_out = 1726764±16 raw, or 1048576±32 with CORDIC_GAIN_COMP_EN.
  - out_valid is first high at accept+17 (accept+18 with CORDIC_GAIN_COMP_EN).
- **Positive y-axis:**
  - Stimulus: x=0, y=16384.
  - Response: theta_out = 12868±2; r_out as in the previous scenario.
- **Negative x-axis and third quadrant:**
  - x=−16384, y=0 → |theta_out| = 25736±2.
  - x=−8192, y=−8192 → theta_out = −19302±3.
- **Zero input:** x=0, y=0 → r_out=0, theta_out=0.
- **Backpressure:**
  - Stimulus: out_ready low for 10 cycles after out_valid, with in_valid held high and new data driven.
  - Response: outputs stable and in_ready=0 during the 10 cycles; the second sample is accepted only after the handshake.

Source files
------------

// File: rtl/cordic_vectoring_core.sv
// Iterative CORDIC vectoring engine: rotates (x, y) onto +x, yielding angle and magnitude.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from r_out.
module cordic_vectoring_core #(
  parameter int unsigned NUM_ITER = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [23:0] r_out,
  output logic signed [15:0] theta_out,
  output logic               busy
);

  localparam int unsigned      IW        = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic [IW-1:0]    ITER_LAST = IW'(NUM_ITER - 1);
  localparam logic signed [15:0] HALF_PI = 16'sd12868;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
`endif

  state_t                state_q;
  logic signed [23:0]    xr_q, yr_q, r_out_q;
  logic signed [15:0]    zr_q, theta_out_q;
  logic [IW-1:0]         iter_q;
  logic                  zero_q, out_valid_q;

  logic signed [23:0]    vx, vy, x_load_d, y_load_d;
  logic signed [15:0]    z_load_d;
  logic signed [23:0]    x_shf, y_shf, x_rot_d, y_rot_d;
  logic signed [15:0]    z_rot_d, atan_v;

  function automatic logic signed [15:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    return 16'sd6434;
      5'd1:    return 16'sd3798;
      5'd2:    return 16'sd2007;
      5'd3:    return 16'sd1019;
      5'd4:    return 16'sd511;
      5'd5:    return 16'sd256;
      5'd6:    return 16'sd128;
      5'd7:    return 16'sd64;
      5'd8:    return 16'sd32;
      5'd9:    return 16'sd16;
      5'd10:   return 16'sd8;
      5'd11:   return 16'sd4;
      5'd12:   return 16'sd2;
      5'd13:   return 16'sd1;
      default: return '0;
    endcase
  endfunction

  // Left-half-plane inputs are pre-rotated by +/-90 deg so the iterations always converge.
  always_comb begin
    vx = {{2{x_in[15]}}, x_in, 6'd0};
    vy = {{2{y_in[15]}}, y_in, 6'd0};
    if (!x_in[15]) begin
      x_load_d = vx;
      y_load_d = vy;
      z_load_d = '0;
    end else if (!y_in[15]) begin
      x_load_d = vy;
      y_load_d = -vx;
      z_load_d = HALF_PI;
    end else begin
      x_load_d = -vy;
      y_load_d = vx;
      z_load_d = -HALF_PI;
    end
  end

  always_comb begin
    x_shf  = xr_q >>> iter_q;
    y_shf  = yr_q >>> iter_q;
    atan_v = atan_lut(5'(iter_q));
    if (!yr_q[23]) begin
      x_rot_d = xr_q + y_shf;
      y_rot_d = yr_q - x_shf;
      z_rot_d = zr_q + atan_v;
    end else begin
      x_rot_d = xr_q - y_shf;
      y_rot_d = yr_q + x_shf;
      z_rot_d = zr_q - atan_v;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [21:0] K_Q022 = 22'd2547004;
  logic signed [46:0] prod;
  logic signed [23:0] r_scaled_d;
  always_comb begin
    prod       = xr_q * $signed({1'b0, K_Q022});
    r_scaled_d = 24'(prod >>> 22);
  end
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      xr_q        <= '0;
      yr_q        <= '0;
      zr_q        <= '0;
      iter_q      <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      r_out_q     <= '0;
      theta_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xr_q    <= x_load_d;
            yr_q    <= y_load_d;
            zr_q    <= z_load_d;
            zero_q  <= (x_in == '0) && (y_in == '0);
            iter_q  <= '0;
            state_q <= ROT;
          end
        end
        ROT: begin
          xr_q   <= x_rot_d;
          yr_q   <= y_rot_d;
          zr_q   <= z_rot_d;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) begin
            iter_q <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= SCALE;
`else
            // Result registers load from the final iteration so out_valid rises with DONE.
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            r_out_q     <= x_rot_d;
            theta_out_q <= zero_q ? '0 : z_rot_d;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          r_out_q     <= r_scaled_d;
          theta_out_q <= zero_q ? '0 : zr_q;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign r_out     = r_out_q;
  assign theta_out = theta_out_q;

endmodule

// File: tb/tb_cordic_vectoring_core.sv
// Directed bench for cordic_vectoring_core: axis/quadrant angles, zero input, reset, backpressure.
// Honours CORDIC_GAIN_COMP_EN for expected latency and magnitude.
module tb_cordic_vectoring_core;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic               in_ready, out_valid, busy;
  logic signed [23:0] r_out;
  logic signed [15:0] theta_out;

  int checks = 0;
  int failures = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT   = 18;
  localparam int R_EXP = 1048576;
  localparam int R_TOL = 32;
`else
  localparam int LAT   = 17;
  localparam int R_EXP = 1726764;
  localparam int R_TOL = 16;
`endif

  cordic_vectoring_core #(.NUM_ITER(16)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .theta_out (theta_out),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; the accept edge is the next one.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y);
    check_eq("ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat = index of the first edge (counted from accept) that samples out_valid high.
  task automatic wait_result(output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    lat = n + 1;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_ready_rise"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int th;
    logic seen;
    logic signed [23:0] r_hold;
    logic signed [15:0] th_hold;
    logic stable, rdy_low;

    // Power-up reset
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_r_out", r_out, 0);
    check_eq("rst_theta", theta_out, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Reset five cycles after accept discards the sample
    send(16'sd16384, 16'sd0);
    check_eq("midop_busy", busy, 1);
    check_eq("midop_in_ready", in_ready, 0);
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_r_out", r_out, 0);
    check_eq("midrst_theta", theta_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge ap_clk);
      #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("midrst_no_valid", seen, 0);

    // Positive x-axis
    send(16'sd16384, 16'sd0);
    wait_result(lat);
    check_eq("posx_latency", lat, LAT);
    check_near("posx_theta", int'(theta_out), 0, 2);
    check_near("posx_r", int'(r_out), R_EXP, R_TOL);
    take("posx");

    // Positive y-axis
    send(16'sd0, 16'sd16384);
    wait_result(lat);
    check_eq("posy_latency", lat, LAT);
    check_near("posy_theta", int'(theta_out), 12868, 2);
    check_near("posy_r", int'(r_out), R_EXP, R_TOL);
    take("posy");

    // Negative x-axis (angle may land on either side of +/-pi)
    send(-16'sd16384, 16'sd0);
    wait_result(lat);
    check_eq("negx_latency", lat, LAT);
    th = int'(theta_out);
    if (th < 0) th = -th;
    check_near("negx_abs_theta", th, 25736, 2);
    check_near("negx_r", int'(r_out), R_EXP, R_TOL);
    take("negx");

    // Third quadrant, -3pi/4
    send(-16'sd8192, -16'sd8192);
    wait_result(lat);
    check_eq("q3_latency", lat, LAT);
    check_near("q3_theta", int'(theta_out), -19302, 3);
    take("q3");

    // Zero input forces theta to zero
    send(16'sd0, 16'sd0);
    wait_result(lat);
    check_eq("zero_latency", lat, LAT);
    check_eq("zero_r", r_out, 0);
    check_eq("zero_theta", theta_out, 0);
    take("zero");

    // Backpressure with a second sample pending on the input
    send(16'sd16384, 16'sd0);
    wait_result(lat);
    check_eq("bp_latency", lat, LAT);
    r_hold   = r_out;
    th_hold  = theta_out;
    in_valid = 1'b1;
    x_in     = 16'sd0;
    y_in     = 16'sd16384;
    stable   = 1'b1;
    rdy_low  = 1'b1;
    repeat (10) begin
      @(posedge ap_clk);
      #1;
      if (out_valid !== 1'b1 || r_out !== r_hold || theta_out !== th_hold) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check_eq("bp_outputs_stable", stable, 1);
    check_eq("bp_in_ready_low", rdy_low, 1);
    check_near("bp_theta", int'(th_hold), 0, 2);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_valid_drop", out_valid, 0);
    check_eq("bp_ready_rise", in_ready, 1);
    check_eq("bp_not_yet_busy", busy, 0);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_second_accepted", busy, 1);
    wait_result(lat);
    check_eq("bp2_latency", lat, LAT);
    check_near("bp2_theta", int'(theta_out), 12868, 2);
    check_near("bp2_r", int'(r_out), R_EXP, R_TOL);
    take("bp2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
